alu_muldiv_ctrl: RTL and testbench

//  Parametrised successor to the combinational ALU decoder for the MIPS core. Decodes aluop/funct
//  and executes the operation. Single-cycle ops return a registered result after 1 cycle.

---
 rtl/alu_muldiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU with a registered single-cycle path plus an iterative multiply/divide unit.
// HI/LO hold the last mult/div outcome; mfhi/mflo read them back.
module alu_muldiv_ctrl #(
    parameter int WIDTH      = 32,
    parameter int HAS_MULDIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam bit MD = (HAS_MULDIV != 0);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi, lo, mag;
    logic [2*WIDTH-1:0] acc;
    logic               is_div, neg_q, neg_r, div_zero;

    logic [WIDTH-1:0]   op_res;
    logic               op_illegal, op_md, op_div, op_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    always_comb begin
        op_res     = '0;
        op_illegal = 1'b0;
        op_md      = 1'b0;
        op_div     = 1'b0;
        op_signed  = 1'b0;
        if (!aluop[1]) begin
            op_res = aluop[0] ? a - b : a + b;
        end else begin
            case (funct)
                6'b100000: op_res = a + b;
                6'b100010: op_res = a - b;
                6'b100100: op_res = a & b;
                6'b100101: op_res = a | b;
                6'b100110: op_res = a ^ b;
                6'b100111: op_res = ~(a | b);
                6'b101010: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                6'b101011: op_res = {{(WIDTH-1){1'b0}}, (a < b)};
                6'b010000: if (MD) op_res = hi; else op_illegal = 1'b1;
                6'b010010: if (MD) op_res = lo; else op_illegal = 1'b1;
                6'b011000: begin op_md = MD; op_signed = 1'b1; op_illegal = !MD; end
                6'b011001: begin op_md = MD; op_illegal = !MD; end
                6'b011010: begin op_md = MD; op_div = 1'b1; op_signed = 1'b1; op_illegal = !MD; end
                6'b011011: begin op_md = MD; op_div = 1'b1; op_illegal = !MD; end
                default:   op_illegal = 1'b1;
            endcase
        end
        a_neg = op_signed & a[WIDTH-1];
        b_neg = op_signed & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
    logic [WIDTH:0]     sum, shifted, diff;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic               ge;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
        mul_next = {sum, acc[WIDTH-1:1]};
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, mag};
        ge       = !diff[WIDTH];
        rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        div_next = {rem_next, acc[WIDTH-2:0], ge};
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            fix_lo = div_zero ? '1 : (neg_q ? -quo : quo);
            fix_hi = neg_r ? -rem : rem;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            hi        <= '0;
            lo        <= '0;
            mag       <= '0;
            acc       <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    if (op_md) begin
                        state    <= ITER;
                        count    <= '0;
                        is_div   <= op_div;
                        mag      <= op_div ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (b == '0);
                    end else begin
                        out_valid <= 1'b1;
                        result    <= op_res;
                        zero      <= (op_res == '0);
                        illegal   <= op_illegal;
                    end
                end
                ITER: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + 1'b1;
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    hi        <= fix_hi;
                    lo        <= fix_lo;
                    result    <= fix_lo;
                    zero      <= (fix_lo == '0);
                    illegal   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl: 32-bit and 8-bit instances against an arithmetic model.
// Directed checks for the worked examples, then randomized operations.
module tb_alu_muldiv_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid32, in_valid8;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a, b;

    logic        rdy32, ov32, zero32, ill32;
    logic [31:0] res32;
    logic        rdy8, ov8, zero8, ill8;
    logic [7:0]  res8;

    int compared   = 0;
    int mismatched = 0;

    longint unsigned hi32_m = 0, lo32_m = 0, hi8_m = 0, lo8_m = 0;
    logic [31:0]     last_res;

    alu_muldiv_ctrl #(.WIDTH(32), .HAS_MULDIV(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(rdy32),
        .aluop(aluop), .funct(funct), .a(a), .b(b),
        .out_valid(ov32), .result(res32), .zero(zero32), .illegal(ill32)
    );

    alu_muldiv_ctrl #(.WIDTH(8), .HAS_MULDIV(1)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(rdy8),
        .aluop(aluop), .funct(funct), .a(a[7:0]), .b(b[7:0]),
        .out_valid(ov8), .result(res8), .zero(zero8), .illegal(ill8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic longint sext(input longint unsigned x, input int w);
        return $signed(x << (64 - w)) >>> (64 - w);
    endfunction

    // Architectural reference: plain integer arithmetic on w-bit values.
    task automatic ref_model(input int w, input logic [1:0] op, input logic [5:0] f,
                             input longint unsigned av, input longint unsigned bv,
                             inout longint unsigned hi, inout longint unsigned lo,
                             output longint unsigned res, output bit ill, output bit multi);
        longint unsigned mask;
        longint          sa, sb;
        longint unsigned p;
        mask  = (64'd1 << w) - 1;
        sa    = sext(av, w);
        sb    = sext(bv, w);
        res   = 0;
        ill   = 0;
        multi = 0;
        if (op == 2'b00)      res = (av + bv) & mask;
        else if (op == 2'b01) res = (av - bv) & mask;
        else begin
            case (f)
                6'h20: res = (av + bv) & mask;
                6'h22: res = (av - bv) & mask;
                6'h24: res = av & bv;
                6'h25: res = av | bv;
                6'h26: res = av ^ bv;
                6'h27: res = ~(av | bv) & mask;
                6'h2a: res = (sa < sb) ? 1 : 0;
                6'h2b: res = (av < bv) ? 1 : 0;
                6'h10: res = hi;
                6'h12: res = lo;
                6'h18, 6'h19: begin
                    p  = (f == 6'h18) ? longint'(sa * sb) : av * bv;
                    hi = (p >> w) & mask;
                    lo = p & mask;
                    res = lo;
                    multi = 1;
                end
                6'h1a, 6'h1b: begin
                    if (bv == 0) begin
                        lo = mask;
                        hi = av;
                    end else if (f == 6'h1a) begin
                        lo = longint'(sa / sb) & mask;
                        hi = longint'(sa % sb) & mask;
                    end else begin
                        lo = av / bv;
                        hi = av % bv;
                    end
                    res = lo;
                    multi = 1;
                end
                default: ill = 1;
            endcase
        end
    endtask

    task automatic applyStimulus(input bit sel8, input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] av, input logic [31:0] bv);
        int              w, guard, lat;
        longint unsigned mask, hi_m, lo_m, exp_res;
        bit              exp_ill, exp_multi;
        w    = sel8 ? 8 : 32;
        mask = (64'd1 << w) - 1;
        hi_m = sel8 ? hi8_m : hi32_m;
        lo_m = sel8 ? lo8_m : lo32_m;
        ref_model(w, op, f, av & mask, bv & mask, hi_m, lo_m, exp_res, exp_ill, exp_multi);
        if (sel8) begin hi8_m = hi_m; lo8_m = lo_m; end
        else begin hi32_m = hi_m; lo32_m = lo_m; end

        aluop = op; funct = f; a = av; b = bv;
        if (sel8) in_valid8 = 1'b1; else in_valid32 = 1'b1;
        guard = 0;
        while (!(sel8 ? rdy8 : rdy32) && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        checkOutput("in_ready", sel8 ? rdy8 : rdy32, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0; in_valid32 = 1'b0;
        lat = 1;
        // Scramble the inputs while busy: they must not matter after the accept edge.
        while (!(sel8 ? ov8 : ov32) && lat < 100) begin
            a = $urandom; b = $urandom; funct = 6'($urandom);
            @(posedge clk); #1; lat++;
        end
        last_res = sel8 ? {24'b0, res8} : res32;
        checkOutput("latency", lat, exp_multi ? w + 2 : 1);
        checkOutput("result", last_res, exp_res);
        checkOutput("zero", sel8 ? zero8 : zero32, exp_res == 0);
        checkOutput("illegal", sel8 ? ill8 : ill32, exp_ill);
        @(posedge clk); #1;
        checkOutput("single_pulse", sel8 ? ov8 : ov32, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] codes [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                               6'h2b, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b};

    initial begin
        longint unsigned exp_res, hi_m, lo_m;
        bit              exp_ill, exp_multi;
        int              busy, pulses;
        longint unsigned b2b_exp [4];
        logic [5:0]      f;

        reset = 1'b1; in_valid32 = 1'b0; in_valid8 = 1'b0;
        aluop = 2'b00; funct = 6'h0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", ov32, 0);
        checkOutput("reset_result", res32, 0);
        checkOutput("reset_zero", zero32, 0);
        checkOutput("reset_illegal", ill32, 0);
        reset = 1'b0;
        #1;
        checkOutput("reset_in_ready", rdy32, 1);
        @(posedge clk); #1;

        $display("[TB] directed single-cycle ops");
        applyStimulus(0, 2'b10, 6'h20, 32'd5, 32'd7);
        checkOutput("add_5_7", last_res, 32'd12);
        applyStimulus(0, 2'b01, 6'h00, 32'd9, 32'd9);
        applyStimulus(0, 2'b10, 6'h2a, 32'hFFFF_FFFF, 32'd1);
        checkOutput("slt_neg1_1", last_res, 32'd1);
        applyStimulus(0, 2'b10, 6'h2b, 32'hFFFF_FFFF, 32'd1);
        checkOutput("sltu_max_1", last_res, 32'd0);

        $display("[TB] directed mult/div");
        applyStimulus(0, 2'b10, 6'h18, 32'hFFFF_FFFD, 32'd7);
        checkOutput("mult_lo", last_res, 32'hFFFF_FFEB);
        applyStimulus(0, 2'b10, 6'h10, 32'd0, 32'd0);
        checkOutput("mult_hi", last_res, 32'hFFFF_FFFF);
        applyStimulus(0, 2'b10, 6'h1a, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_lo", last_res, 32'hFFFF_FFFD);
        applyStimulus(0, 2'b10, 6'h10, 32'd0, 32'd0);
        checkOutput("div_hi", last_res, 32'hFFFF_FFFF);
        applyStimulus(0, 2'b10, 6'h1b, 32'd7, 32'd0);
        checkOutput("divu0_lo", last_res, 32'hFFFF_FFFF);
        applyStimulus(0, 2'b10, 6'h10, 32'd0, 32'd0);
        checkOutput("divu0_hi", last_res, 32'd7);
        applyStimulus(0, 2'b10, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div_min_lo", last_res, 32'h8000_0000);
        applyStimulus(0, 2'b10, 6'h10, 32'd0, 32'd0);
        checkOutput("div_min_hi", last_res, 32'd0);

        $display("[TB] held request during divide");
        hi_m = hi32_m; lo_m = lo32_m;
        ref_model(32, 2'b10, 6'h1a, 64'hFFFF_FFF9, 64'd2, hi_m, lo_m, exp_res, exp_ill, exp_multi);
        hi32_m = hi_m; lo32_m = lo_m;
        aluop = 2'b10; funct = 6'h1a; a = 32'hFFFF_FFF9; b = 32'd2; in_valid32 = 1'b1;
        @(posedge clk); #1;
        funct = 6'h20; a = 32'd100; b = 32'd23;
        busy = 0;
        while (!rdy32 && busy < 100) begin
            busy++;
            @(posedge clk); #1;
        end
        checkOutput("busy_cycles", busy, 33);
        checkOutput("held_div_valid", ov32, 1);
        checkOutput("held_div_result", res32, exp_res);
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        checkOutput("held_add_valid", ov32, 1);
        checkOutput("held_add_result", res32, 32'd123);
        @(posedge clk); #1;
        checkOutput("held_add_pulse", ov32, 0);

        applyStimulus(0, 2'b10, 6'h3f, 32'd3, 32'd4);
        checkOutput("illegal_flag", ill32, 1);
        checkOutput("illegal_result", last_res, 32'd0);

        $display("[TB] back-to-back single-cycle ops");
        in_valid32 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                checkOutput("b2b_valid", ov32, 1);
                checkOutput("b2b_result", res32, b2b_exp[i-1]);
            end
            aluop = 2'b10; a = $urandom; b = $urandom;
            f = codes[$urandom_range(0, 5)];
            funct = f;
            hi_m = hi32_m; lo_m = lo32_m;
            ref_model(32, 2'b10, f, 64'(a), 64'(b), hi_m, lo_m, b2b_exp[i], exp_ill, exp_multi);
        end
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        checkOutput("b2b_valid_last", ov32, 1);
        checkOutput("b2b_result_last", res32, b2b_exp[3]);
        @(posedge clk); #1;
        checkOutput("b2b_idle", ov32, 0);

        $display("[TB] reset during multiply");
        applyStimulus(0, 2'b10, 6'h18, 32'd3, 32'd4);
        applyStimulus(0, 2'b10, 6'h10, 32'd0, 32'd0);
        checkOutput("mult34_hi", last_res, 32'd0);
        applyStimulus(0, 2'b10, 6'h12, 32'd0, 32'd0);
        checkOutput("mult34_lo", last_res, 32'd12);
        aluop = 2'b10; funct = 6'h18; a = 32'd6; b = 32'd7; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1;
        #2;
        reset = 1'b0;
        hi32_m = 0; lo32_m = 0; hi8_m = 0; lo8_m = 0;
        #1;
        checkOutput("abort_out_valid", ov32, 0);
        checkOutput("abort_in_ready", rdy32, 1);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov32) pulses++;
        end
        checkOutput("abort_no_completion", pulses, 0);
        applyStimulus(0, 2'b10, 6'h12, 32'd0, 32'd0);
        checkOutput("abort_mflo", last_res, 32'd0);
        applyStimulus(0, 2'b10, 6'h10, 32'd0, 32'd0);
        checkOutput("abort_mfhi", last_res, 32'd0);

        $display("[TB] 8-bit instance");
        applyStimulus(1, 2'b10, 6'h18, 32'hFD, 32'd7);
        checkOutput("w8_mult_lo", last_res, 32'hEB);
        applyStimulus(1, 2'b10, 6'h10, 32'd0, 32'd0);
        checkOutput("w8_mult_hi", last_res, 32'hFF);
        applyStimulus(1, 2'b10, 6'h1a, 32'hF9, 32'd2);
        checkOutput("w8_div_lo", last_res, 32'hFD);
        applyStimulus(1, 2'b10, 6'h1b, 32'd7, 32'd0);
        checkOutput("w8_divu0_lo", last_res, 32'hFF);
        applyStimulus(1, 2'b10, 6'h10, 32'd0, 32'd0);
        checkOutput("w8_divu0_hi", last_res, 32'd7);
        applyStimulus(1, 2'b10, 6'h1a, 32'h80, 32'hFF);
        checkOutput("w8_div_min_lo", last_res, 32'h80);

        $display("[TB] randomized ops");
        for (int i = 0; i < 40; i++) begin
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 13)];
            applyStimulus(0, 2'($urandom_range(0, 3)), f, pick_operand(), pick_operand());
        end
        for (int i = 0; i < 20; i++) begin
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 13)];
            applyStimulus(1, 2'($urandom_range(0, 3)), f, pick_operand(), pick_operand());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
